mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the word-wide data RAM port; sits between the MEM stage of the pipeline and the RAM.
- Accepts byte-addressed load/store requests (byte, halfword, word; signed/unsigned loads) and converts them into word RAM accesses.
- Sub-word stores use read-modify-write (RMW); misaligned requests are flagged and never reach the RAM.
- Drives the RAM's mem_write/addr/write_data and consumes its read_data (synchronous read: data valid the cycle after addr is presented).

Parameters:
ADDR_WIDTH, 5, RAM word-address width; word index = req_addr[ADDR_WIDTH+1:2], upper bits ignored (wrap)
DATA_WIDTH, 32, RAM word width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_error  out  1  misaligned/illegal flag, qualified by resp_valid
resp_data  out  32  extended load data; held until the next load response
ram_mem_write  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM word address
ram_write_data  out  DATA_WIDTH  RAM write data
ram_read_data  in  DATA_WIDTH  RAM read data, valid one cycle after ram_addr

Behaviour:
- One clock; reset is synchronous and active-high: clk, rst.
- Reset values: state IDLE, ram_mem_write 0, ram_addr 0, ram_write_data 0, resp_valid 0, resp_error 0, resp_data 0. req_ready is 0 while rst is high and 1 in IDLE otherwise.
- Byte lanes are little-endian: byte offset k occupies bits 8k+7:8k.
- Request attributes are registered at acceptance; inputs are don't-care afterwards.
- FSM states: IDLE, RD_ISSUE, RD_CAPTURE, WR, RESP. req_ready is 1 only in IDLE.
- Acceptance (cycle c0) routing:
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or req_size=11 -> RESP with error.
  - Word store -> WR.
  - Load or sub-word store -> RD_ISSUE.
- RD_ISSUE: ram_addr = word index.
- RD_CAPTURE: latch ram_read_data.
  - Load -> RESP; resp_data = selected byte/half, extended per req_unsigned (word loads pass through).
  - Sub-word store -> WR; merged word = captured word with the addressed lane(s) replaced by req_wdata[7:0] or req_wdata[15:0].
- WR: ram_mem_write = 1 for exactly one cycle, with ram_addr and ram_write_data (full word or merged word), then -> RESP.
- RESP: resp_valid = 1 for one cycle (resp_error as decided); -> IDLE.
- Latency from accept to resp_valid:
  - word store 2 cycles (WR at c1)
  - load 3 cycles
  - sub-word store 4 cycles (WR at c3)
  - error 1 cycle
- Next request is accepted no earlier than the cycle after RESP.
- ram_mem_write is gated combinationally with !rst: rst asserted in the WR cycle suppresses the write. Reset in any state aborts the operation with no response and no RAM write.
- Error responses leave resp_data unchanged and never assert ram_mem_write.
- Address wrap: word index is taken modulo 2^ADDR_WIDTH (0x80 maps to word 0 at ADDR_WIDTH=5).
- ram_mem_write is never asserted outside WR.

Test Plan:
- sw 0xDEADBEEF @0x0C, then lw @0x0C -> ram_mem_write pulses at c1 with ram_addr=3; load resp_valid at accept+3 with resp_data=0xDEADBEEF, resp_error=0.
- Word 4 = 0xCAFEBABE; sb 0xAB @0x11 -> single write at accept+3, ram_addr=4, ram_write_data=0xCAFEABBE; resp_valid at accept+4.
- After the sb: lb @0x11 -> 0xFFFFFFAB; lbu @0x11 -> 0x000000AB; lh @0x12 -> 0xFFFFCAFE; lhu @0x12 -> 0x0000CAFE.
- lw @0x0E, sh @0x05, req_size=11 -> resp_valid+resp_error one cycle after accept; ram_mem_write stays 0; resp_data unchanged.
- rst asserted during the WR cycle of an sh -> ram_mem_write 0 that cycle, no resp_valid, req_ready=1 after reset release; memory word unchanged.
- sw 0x12345678 @0x80 (ADDR_WIDTH=5) -> ram_addr=0; back-to-back req_valid held high -> req_ready low until the cycle after RESP.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide synchronous-read data RAM.
// Sub-word stores are read-modify-write; misaligned or illegal requests are
// answered with an error and never touch the RAM.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [31:0]           resp_data,
  output logic                  ram_mem_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;

  logic        accept_c;
  logic        misaligned_c;
  logic [4:0]  lane_shift_c;
  logic [7:0]  rd_byte_c;
  logic [15:0] rd_half_c;
  logic [31:0] load_ext_c;
  logic [31:0] merged_c;

  // Address bits above the word index wrap and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Handshake and write strobe are gated with reset so nothing leaks while rst is high.
  assign req_ready     = (state_q == IDLE) && !rst;
  assign ram_mem_write = (state_q == WR) && !rst;
  assign accept_c      = req_valid && req_ready;

  // Misaligned halfword/word or illegal size.
  always_comb begin
    misaligned_c = 1'b0;
    case (req_size)
      SIZE_BYTE: misaligned_c = 1'b0;
      SIZE_HALF: misaligned_c = req_addr[0];
      SIZE_WORD: misaligned_c = (req_addr[1:0] != 2'b00);
      default:   misaligned_c = 1'b1;
    endcase
  end

  // Lane extraction with sign/zero extension, and sub-word merge for RMW stores.
  always_comb begin
    lane_shift_c = {req_q.offset, 3'b000};
    rd_byte_c    = ram_read_data[lane_shift_c +: 8];
    rd_half_c    = req_q.offset[1] ? ram_read_data[31:16] : ram_read_data[15:0];
    load_ext_c   = ram_read_data;
    merged_c     = ram_read_data;
    case (req_q.size)
      SIZE_BYTE: begin
        load_ext_c = req_q.is_unsigned ? {24'd0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
        merged_c[lane_shift_c +: 8] = req_q.wdata[7:0];
      end
      SIZE_HALF: begin
        load_ext_c = req_q.is_unsigned ? {16'd0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
        if (req_q.offset[1]) merged_c[31:16] = req_q.wdata[15:0];
        else                 merged_c[15:0]  = req_q.wdata[15:0];
      end
      default: begin
        load_ext_c = ram_read_data;
        merged_c   = ram_read_data;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (misaligned_c)                             state_d = RESP;
          else if (req_write && req_size == SIZE_WORD)  state_d = WR;
          else                                          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = req_q.write ? WR : RESP;
      WR:         state_d = RESP;
      RESP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Request capture, RAM address/data and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q          <= '0;
      ram_addr       <= '0;
      ram_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_data      <= '0;
    end else begin
      resp_valid <= (state_d == RESP);
      resp_error <= 1'b0;
      if (accept_c) begin
        req_q    <= '{write: req_write, size: req_size, is_unsigned: req_unsigned,
                      offset: req_addr[1:0], wdata: req_wdata};
        ram_addr <= req_addr[ADDR_WIDTH+1:2];
        if (misaligned_c)
          resp_error <= 1'b1;
        else if (req_write && req_size == SIZE_WORD)
          ram_write_data <= DATA_WIDTH'(req_wdata);
      end
      if (state_q == RD_CAPTURE) begin
        if (req_q.write) ram_write_data <= DATA_WIDTH'(merged_c);
        else             resp_data      <= load_ext_c;
      end
    end
  end

endmodule
